// File: rtl/btn_debounce_multi_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel
// push-button debouncer.
//   DB_20MS_100MHZ / LONG_1S_100MHZ / RPT_200MS_100MHZ : default periods
//   period_ok()        : range test for a period against a counter width
//   BDM_CHECK_PERIOD   : generate-scope check that stops elaboration on a
//                        period outside 1 .. 2^CNT_W-1
`ifndef BTN_DEBOUNCE_MULTI_PKG_SV
`define BTN_DEBOUNCE_MULTI_PKG_SV

`define BDM_CHECK_PERIOD(P, W, LBL) \
  if (!btn_debounce_multi_pkg::period_ok(longint'(P), W)) begin : LBL \
    $error("period %0d outside 1..2^%0d-1", P, W); \
  end

package btn_debounce_multi_pkg;
  localparam int unsigned DB_20MS_100MHZ   = 2_000_000;
  localparam int unsigned LONG_1S_100MHZ   = 100_000_000;
  localparam int unsigned RPT_200MS_100MHZ = 20_000_000;
  localparam int          DEF_NUM_CH       = 4;
  localparam int          DEF_CNT_W        = 32;

  function automatic bit period_ok(input longint p, input int w);
    if (w >= 63) return p >= 1;
    return (p >= 1) && (p < (longint'(1) << w));
  endfunction
endpackage

`endif

// File: rtl/btn_debounce_multi_if.sv
// Button bundle between pins/application and the debouncer.
//   btn_in, rpt_en               : raw pins and per-channel repeat enable
//   btn_level, btn_press,
//   btn_release, btn_long        : debounced level and one-cycle strobes
// master = pin/application side, slave = debouncer.
interface btn_debounce_multi_if
  import btn_debounce_multi_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
);
  logic [NUM_CH-1:0] btn_in;
  logic [NUM_CH-1:0] rpt_en;
  logic [NUM_CH-1:0] btn_level;
  logic [NUM_CH-1:0] btn_press;
  logic [NUM_CH-1:0] btn_release;
  logic [NUM_CH-1:0] btn_long;

  modport master (output btn_in, rpt_en,
                  input  btn_level, btn_press, btn_release, btn_long);
  modport slave  (input  btn_in, rpt_en,
                  output btn_level, btn_press, btn_release, btn_long);
endinterface

// File: rtl/btn_debounce_multi_debounce_ch.sv
// Single button channel: polarity normalise, 2-FF synchroniser,
// consecutive-cycle debouncer, hold counter with long-press strobe and
// auto-repeat of the press strobe.
//   clk, reset_n : clock, synchronous active-low reset
//   btn_in       : raw pin
//   rpt_en       : gates auto-repeat press strobes
//   level        : debounced pressed level
//   press, rel   : one-cycle press (incl. repeats) / release strobes
//   long_p       : one-cycle strobe when the hold reaches LONG_PERIOD
module debounce_ch
  import btn_debounce_multi_pkg::*;
#(
  parameter int unsigned DEBOUNCE_PERIOD = DB_20MS_100MHZ,
  parameter int unsigned LONG_PERIOD     = LONG_1S_100MHZ,
  parameter int unsigned REPEAT_PERIOD   = RPT_200MS_100MHZ,
  parameter int          CNT_W           = DEF_CNT_W,
  parameter bit          ACTIVE_HIGH     = 1'b1
)(
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  input  logic rpt_en,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_p
);
  `BDM_CHECK_PERIOD(DEBOUNCE_PERIOD, CNT_W, g_chk_db)
  `BDM_CHECK_PERIOD(LONG_PERIOD,     CNT_W, g_chk_long)
  `BDM_CHECK_PERIOD(REPEAT_PERIOD,   CNT_W, g_chk_rpt)

  localparam logic [CNT_W-1:0] DB_M1   = CNT_W'(DEBOUNCE_PERIOD - 1);
  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_PERIOD - 1);
  localparam logic [CNT_W-1:0] RPT_M1  = CNT_W'(REPEAT_PERIOD - 1);

  logic             norm, sync1, sync2, stable, long_reached;
  logic             differs, flip;
  logic [CNT_W-1:0] db_cnt, hold_cnt, rpt_cnt;

  // Inverting ahead of the synchroniser keeps everything downstream in
  // "1 = pressed" terms and lets reset clear the sync flops to 0.
  assign norm    = ACTIVE_HIGH ? btn_in : ~btn_in;
  assign differs = sync2 != stable;
  assign flip    = differs && (db_cnt == DB_M1);
  assign level   = stable;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      stable       <= 1'b0;
      long_reached <= 1'b0;
      db_cnt       <= '0;
      hold_cnt     <= '0;
      rpt_cnt      <= '0;
      press        <= 1'b0;
      rel          <= 1'b0;
      long_p       <= 1'b0;
    end else begin
      sync1  <= norm;
      sync2  <= sync1;
      press  <= 1'b0;
      rel    <= 1'b0;
      long_p <= 1'b0;

      if (!differs || flip) db_cnt <= '0;
      else                  db_cnt <= db_cnt + 1'b1;
      if (flip) stable <= sync2;

      // Priority order makes a release flip mask any long/repeat strobe
      // landing on the same edge.
      if (flip && !sync2) begin
        rel          <= 1'b1;
        hold_cnt     <= '0;
        rpt_cnt      <= '0;
        long_reached <= 1'b0;
      end else if (flip) begin
        press    <= 1'b1;
        hold_cnt <= CNT_W'(1);
        rpt_cnt  <= '0;
        if (LONG_PERIOD == 1) begin
          long_p       <= 1'b1;
          long_reached <= 1'b1;
        end
      end else if (stable && !long_reached) begin
        // hold_cnt saturates at LONG_PERIOD once long_reached is set
        hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == LONG_M1) begin
          long_p       <= 1'b1;
          long_reached <= 1'b1;
        end
      end else if (stable) begin
        // Free-running phase: rpt_en only gates the strobe
        if (rpt_cnt == RPT_M1) begin
          rpt_cnt <= '0;
          press   <= rpt_en;
        end else begin
          rpt_cnt <= rpt_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel push-button debouncer: one debounce_ch per channel, outputs
// gathered onto the button interface.
//   clk, reset_n : clock, synchronous active-low reset
//   btn (slave)  : btn_in/rpt_en in; btn_level/press/release/long out
module btn_debounce_multi
  import btn_debounce_multi_pkg::*;
#(
  parameter int          NUM_CH          = DEF_NUM_CH,
  parameter int unsigned DEBOUNCE_PERIOD = DB_20MS_100MHZ,
  parameter int unsigned LONG_PERIOD     = LONG_1S_100MHZ,
  parameter int unsigned REPEAT_PERIOD   = RPT_200MS_100MHZ,
  parameter int          CNT_W           = DEF_CNT_W,
  parameter bit          ACTIVE_HIGH     = 1'b1
)(
  input  logic                  clk,
  input  logic                  reset_n,
  btn_debounce_multi_if.slave   btn
);
  logic [NUM_CH-1:0] level, press, rel, long_p;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_PERIOD (DEBOUNCE_PERIOD),
      .LONG_PERIOD     (LONG_PERIOD),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CNT_W           (CNT_W),
      .ACTIVE_HIGH     (ACTIVE_HIGH)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_in  (btn.btn_in[i]),
      .rpt_en  (btn.rpt_en[i]),
      .level   (level[i]),
      .press   (press[i]),
      .rel     (rel[i]),
      .long_p  (long_p[i])
    );
  end

  assign btn.btn_level   = level;
  assign btn.btn_press   = press;
  assign btn.btn_release = rel;
  assign btn.btn_long    = long_p;
endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench: an active-high and an active-low instance receive mutually
// inverted pins and must show identical channel-0 timing; channel 1 stays idle.
// Per-cycle expectations are written as {level, press, release, long}.
module tb_btn_debounce_multi;
  localparam int NCH = 2;
  localparam int DB  = 4;
  localparam int LP  = 20;
  localparam int RP  = 5;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] btn   = '0;
  logic [NCH-1:0] rpt   = '0;
  int             n_cmp = 0;
  int             n_bad = 0;

  btn_debounce_multi_if #(.NUM_CH(NCH)) bus_h ();
  btn_debounce_multi_if #(.NUM_CH(NCH)) bus_l ();

  assign bus_h.btn_in = btn;
  assign bus_h.rpt_en = rpt;
  assign bus_l.btn_in = ~btn;
  assign bus_l.rpt_en = rpt;

  btn_debounce_multi #(.NUM_CH(NCH), .DEBOUNCE_PERIOD(DB), .LONG_PERIOD(LP),
    .REPEAT_PERIOD(RP), .CNT_W(8), .ACTIVE_HIGH(1'b1))
    dut_h (.clk(clk), .reset_n(rst_n), .btn(bus_h));

  btn_debounce_multi #(.NUM_CH(NCH), .DEBOUNCE_PERIOD(DB), .LONG_PERIOD(LP),
    .REPEAT_PERIOD(RP), .CNT_W(8), .ACTIVE_HIGH(1'b0))
    dut_l (.clk(clk), .reset_n(rst_n), .btn(bus_l));

  always #5 clk = ~clk;

  logic [3:0] oh0, ol0, oh1, ol1;
  assign oh0 = {bus_h.btn_level[0], bus_h.btn_press[0], bus_h.btn_release[0], bus_h.btn_long[0]};
  assign ol0 = {bus_l.btn_level[0], bus_l.btn_press[0], bus_l.btn_release[0], bus_l.btn_long[0]};
  assign oh1 = {bus_h.btn_level[1], bus_h.btn_press[1], bus_h.btn_release[1], bus_h.btn_long[1]};
  assign ol1 = {bus_l.btn_level[1], bus_l.btn_press[1], bus_l.btn_release[1], bus_l.btn_long[1]};

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  task automatic obs(input string tag, input logic [3:0] e);
    chk({tag, ".h0"}, oh0, e);
    chk({tag, ".l0"}, ol0, e);
    chk({tag, ".h1"}, oh1, 4'b0000);
    chk({tag, ".l1"}, ol1, 4'b0000);
  endtask

  // Inputs change 1 time unit after an edge; outputs sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn   = '0;
    rpt   = '0;
    tick();
    tick();
    obs("reset", 4'b0000);
    rst_n = 1'b1;
    tick();
    tick();
    obs("post_reset", 4'b0000);
  endtask

  // Press held from hold cycle 1; pin released after hold cycle rel_h, so the
  // release flip lands at hold cycle rel_h+6. Optional gating drops rpt_en in
  // hold cycles 27..33, which removes only the repeat at cycle 30.
  task automatic hold_scen(input string tag, input int rel_h, input bit gate, input int last_h);
    logic [3:0] e;
    bit         p;
    int         rel_edge;
    rel_edge = rel_h + 6;
    do_reset();
    rpt[0] = 1'b1;
    btn[0] = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      obs($sformatf("%s.pre%0d", tag, t), 4'b0000);
    end
    for (int h = 1; h <= last_h; h++) begin
      tick();
      if (h < rel_edge) begin
        p = (h == 1) || (h >= 25 && (h - 20) % 5 == 0 && !(gate && h == 30));
        e = {1'b1, p, 1'b0, (h == 20)};
      end else if (h == rel_edge) begin
        e = 4'b0010;
      end else begin
        e = 4'b0000;
      end
      obs($sformatf("%s.h%0d", tag, h), e);
      if (h == rel_h) btn[0] = 1'b0;
      rpt[0] = !(gate && h + 1 >= 27 && h + 1 <= 33);
    end
  endtask

  initial begin
    // Clean press then release
    do_reset();
    btn[0] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      obs($sformatf("press.c%0d", c), {(c >= 6), (c == 6), 1'b0, 1'b0});
    end
    btn[0] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      obs($sformatf("unpress.c%0d", c), {(c < 6), 1'b0, (c == 6), 1'b0});
    end

    // Glitch of 3 cycles is rejected, 4 cycles is accepted
    do_reset();
    btn[0] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      obs($sformatf("glitch.c%0d", c), 4'b0000);
      if (c == 3) btn[0] = 1'b0;
    end
    btn[0] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      obs($sformatf("run4.c%0d", c),
          {(c >= 6 && c < 10), (c == 6), (c == 10), 1'b0});
      if (c == 4) btn[0] = 1'b0;
    end

    hold_scen("long_rpt",  60, 1'b0, 70); // repeats through 65, release at 66
    hold_scen("rpt_gate",  40, 1'b1, 50); // repeat 30 missing
    hold_scen("rel_long",  14, 1'b0, 26); // release on long boundary
    hold_scen("rel_rpt",   59, 1'b0, 70); // release on repeat boundary

    // Reset while held: fresh press 6 cycles after the reset edge
    do_reset();
    btn[0] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      obs($sformatf("mid.c%0d", c), {(c >= 6), (c == 6), 1'b0, 1'b0});
    end
    rst_n = 1'b0;
    tick();
    obs("mid.rst", 4'b0000);
    rst_n = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      obs($sformatf("mid.re%0d", c), {(c >= 6), (c == 6), 1'b0, 1'b0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
